// File: rtl/one_pixel_dvd_rx.sv
// ----------------------------------------------------------------------------
// one_pixel_dvd_rx
//
// Watches a TinyVGA PMOD video stream and looks for pixels of one key colour.
// For every frame it reports where the first matching visible pixel was,
// how many matched (saturating at 15) and which way the dot moved compared
// with the last frame that contained it. It also checks the incoming line and
// frame lengths against the timing parameters and reports lock.
//
// Ports
//   clk         pixel clock, single clock domain
//   reset       synchronous active-high reset
//   vga_in      PMOD bus {hsync,B0,G0,R0,vsync,B1,G1,R1}
//   key_color   colour to look for {R1,R0,G1,G0,B1,B0}
//   dot_x/y     visible coordinate of the first match of the last frame
//   dot_found   last frame had at least one match
//   dot_count   matches in the last frame, saturating at 15
//   dir_x/y     1 = coordinate grew compared with the previous found frame
//   frame_done  one-cycle pulse whenever the frame outputs are updated
//   locked      incoming timing has matched the parameters for two frames
// ----------------------------------------------------------------------------
module one_pixel_dvd_rx #(
  parameter int H_DISPLAY       = 640,
  parameter int H_SYNC          = 96,
  parameter int H_BACK          = 48,
  parameter int H_TOTAL         = 800,
  parameter int V_DISPLAY       = 480,
  parameter int V_SYNC          = 2,
  parameter int V_BACK          = 33,
  parameter int V_TOTAL         = 525,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] vga_in,
  input  logic [5:0] key_color,
  output logic [9:0] dot_x,
  output logic [9:0] dot_y,
  output logic       dot_found,
  output logic [3:0] dot_count,
  output logic       dir_x,
  output logic       dir_y,
  output logic       frame_done,
  output logic       locked
);

  localparam int         H_START   = H_SYNC + H_BACK;
  localparam int         V_START   = V_SYNC + V_BACK;
  localparam logic       SYNC_IDLE = (SYNC_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [9:0] POS_MAX   = 10'h3FF;

  // Input sample and edge detection
  logic [7:0] vga_q;
  logic       hs, vs;
  logic       hs_prev, vs_prev;
  logic       hs_edge, vs_edge;
  logic [5:0] color;

  // Position of the previous sample, and of the current one
  logic [9:0] hpos, line;
  logic [9:0] hpos_cur, line_cur;
  logic       line_start;

  // Frame bookkeeping
  logic       armed;      // vsync seen, waiting for the hsync that begins line 0
  logic       in_frame;   // a line 0 has been begun since reset
  logic       h_seen;     // an hsync edge has been seen, so hpos measures a line
  logic       lines_ok;   // every line of the current frame had the right length

  // Per-frame accumulators
  logic [9:0] acc_x, acc_y;
  logic [3:0] acc_count;

  // Last found coordinates, for the direction outputs
  logic [9:0] prev_x, prev_y;
  logic       have_prev;

  logic [1:0] lock_cnt;

  // Visibility / match
  logic       h_vis, v_vis;
  logic [9:0] x_vis, y_vis;
  logic       frame_active;
  logic       match;

  // Timing checks
  logic       line_len_ok;
  logic       bad_line;
  logic       frame_ok;
  logic       acc_found;

  // Syncs are normalised to active-high; XOR with the idle level does both polarities.
  assign hs    = vga_q[7] ^ SYNC_IDLE;
  assign vs    = vga_q[3] ^ SYNC_IDLE;
  assign color = {vga_q[0], vga_q[4], vga_q[1], vga_q[5], vga_q[2], vga_q[6]};

  assign hs_edge = hs & ~hs_prev;
  assign vs_edge = vs & ~vs_prev;

  assign hpos_cur = hs_edge ? 10'd0 :
                    ((hpos == POS_MAX) ? POS_MAX : hpos + 10'd1);

  // A simultaneous vsync edge counts as arming first, so the hsync begins line 0.
  assign line_start = hs_edge & (armed | vs_edge);
  assign line_cur   = line_start ? 10'd0 :
                      (hs_edge ? ((line == POS_MAX) ? POS_MAX : line + 10'd1) : line);

  assign h_vis = ({1'b0, hpos_cur} >= 11'(H_START)) &&
                 ({1'b0, hpos_cur} <  11'(H_START + H_DISPLAY));
  assign v_vis = ({1'b0, line_cur} >= 11'(V_START)) &&
                 ({1'b0, line_cur} <  11'(V_START + V_DISPLAY));
  assign x_vis = hpos_cur - 10'(H_START);
  assign y_vis = line_cur - 10'(V_START);

  // Samples taken before the first line 0 after reset, or in the gap between
  // a vsync edge and the line it arms, belong to no frame. The vsync-edge
  // sample itself is dropped because the accumulators are cleared there.
  assign frame_active = (in_frame & ~armed) | line_start;
  assign match        = frame_active & ~vs_edge & h_vis & v_vis & (color == key_color);

  assign line_len_ok = (({1'b0, hpos} + 11'd1) == 11'(H_TOTAL));
  assign bad_line    = hs_edge & h_seen & ~line_len_ok;

  // hsync is processed before frame start, so a line ending on the vsync
  // edge still counts toward the frame that is closing.
  assign frame_ok = in_frame & ~armed & lines_ok & ~bad_line &
                    (({1'b0, line} + 11'd1) == 11'(V_TOTAL));

  assign acc_found = (acc_count != 4'd0);
  assign locked    = (lock_cnt == 2'd2);

  always_ff @(posedge clk) begin
    if (reset) begin
      // Idle sync levels so that no edge is seen on the first sample after reset.
      vga_q      <= {SYNC_IDLE, 3'b000, SYNC_IDLE, 3'b000};
      hs_prev    <= 1'b0;
      vs_prev    <= 1'b0;
      hpos       <= 10'd0;
      line       <= 10'd0;
      armed      <= 1'b0;
      in_frame   <= 1'b0;
      h_seen     <= 1'b0;
      lines_ok   <= 1'b0;
      acc_x      <= 10'd0;
      acc_y      <= 10'd0;
      acc_count  <= 4'd0;
      prev_x     <= 10'd0;
      prev_y     <= 10'd0;
      have_prev  <= 1'b0;
      lock_cnt   <= 2'd0;
      dot_x      <= 10'd0;
      dot_y      <= 10'd0;
      dot_found  <= 1'b0;
      dot_count  <= 4'd0;
      dir_x      <= 1'b0;
      dir_y      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      vga_q   <= vga_in;
      hs_prev <= hs;
      vs_prev <= vs;
      hpos    <= hpos_cur;
      line    <= line_cur;

      if (hs_edge) h_seen <= 1'b1;

      if (line_start)   armed <= 1'b0;
      else if (vs_edge) armed <= 1'b1;

      if (line_start) in_frame <= 1'b1;

      if (vs_edge)       lines_ok <= 1'b1;
      else if (bad_line) lines_ok <= 1'b0;

      if (bad_line || (vs_edge && !frame_ok)) lock_cnt <= 2'd0;
      else if (vs_edge && lock_cnt != 2'd2)   lock_cnt <= lock_cnt + 2'd1;

      frame_done <= 1'b0;

      if (vs_edge) begin
        acc_x     <= 10'd0;
        acc_y     <= 10'd0;
        acc_count <= 4'd0;
        // Only a frame that began with a line 0 after reset is published.
        if (in_frame) begin
          frame_done <= 1'b1;
          dot_count  <= acc_count;
          dot_found  <= acc_found;
          dot_x      <= acc_found ? acc_x : 10'd0;
          dot_y      <= acc_found ? acc_y : 10'd0;
          if (acc_found) begin
            if (have_prev) begin
              if (acc_x > prev_x)      dir_x <= 1'b1;
              else if (acc_x < prev_x) dir_x <= 1'b0;
              if (acc_y > prev_y)      dir_y <= 1'b1;
              else if (acc_y < prev_y) dir_y <= 1'b0;
            end
            prev_x    <= acc_x;
            prev_y    <= acc_y;
            have_prev <= 1'b1;
          end
        end
      end else if (match) begin
        if (acc_count == 4'd0) begin
          acc_x <= x_vis;
          acc_y <= y_vis;
        end
        if (acc_count != 4'd15) acc_count <= acc_count + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_one_pixel_dvd_rx.sv
// ----------------------------------------------------------------------------
// tb_one_pixel_dvd_rx
//
// Drives whole frames of a reduced-size VGA raster (negative syncs) built from
// a small image array, and compares the published frame results against a
// frame-level model: first match in raster order of the visible image, match
// count clamped to 15, direction against the last found frame, and a lock
// counter advanced once per clean complete frame.
// ----------------------------------------------------------------------------
module tb_one_pixel_dvd_rx;

  localparam int HD = 24, HS = 4, HB = 4, HT = 36;
  localparam int VD = 16, VS = 2, VB = 3, VT = 24;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] vga_in;
  logic [5:0] key_color;
  logic [9:0] dot_x, dot_y;
  logic       dot_found;
  logic [3:0] dot_count;
  logic       dir_x, dir_y, frame_done, locked;

  always #5 clk = ~clk;

  one_pixel_dvd_rx #(
    .H_DISPLAY(HD), .H_SYNC(HS), .H_BACK(HB), .H_TOTAL(HT),
    .V_DISPLAY(VD), .V_SYNC(VS), .V_BACK(VB), .V_TOTAL(VT),
    .SYNC_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset(reset), .vga_in(vga_in), .key_color(key_color),
    .dot_x(dot_x), .dot_y(dot_y), .dot_found(dot_found), .dot_count(dot_count),
    .dir_x(dir_x), .dir_y(dir_y), .frame_done(frame_done), .locked(locked)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [5:0] img [VD][HD];
  logic [5:0] blank_col;

  // Snapshots taken while a frame is driven
  int         pulses, pulse_pos;
  logic [9:0] s_x, s_y;
  logic       s_found, s_dx, s_dy, s_lock, s_lock_end;
  logic [3:0] s_count;
  logic [9:0] z_x, z_y;
  logic       z_found, z_dx, z_dy, z_lock, z_done;
  logic [3:0] z_count;

  // Frame-level model
  logic [9:0] m_x = 0, m_y = 0, m_px = 0, m_py = 0;
  logic       m_found = 0, m_dx = 0, m_dy = 0, m_have = 0;
  int         m_count = 0, m_lock = 0;
  int         pend_cnt = 0, pend_x = 0, pend_y = 0;
  logic       prev_complete = 0, prev_good = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // c = {R1,R0,G1,G0,B1,B0}; bus = {hsync,B0,G0,R0,vsync,B1,G1,R1}, syncs active low
  function automatic logic [7:0] pack(input logic h_act, input logic v_act, input logic [5:0] c);
    return {~h_act, c[0], c[2], c[4], ~v_act, c[1], c[3], c[5]};
  endfunction

  task automatic fill(input logic [5:0] c);
    for (int y = 0; y < VD; y++)
      for (int x = 0; x < HD; x++)
        img[y][x] = c;
  endtask

  task automatic frame_stats(input logic [5:0] key, output int cnt, output int fx, output int fy);
    cnt = 0; fx = 0; fy = 0;
    for (int y = 0; y < VD; y++)
      for (int x = 0; x < HD; x++)
        if (img[y][x] == key) begin
          if (cnt == 0) begin fx = x; fy = y; end
          cnt++;
        end
  endtask

  task automatic run_frame(input int short_line, input int rst_line);
    int len, cyc;
    logic vis;
    logic [5:0] col;
    cyc = 0; pulses = 0; pulse_pos = -1;
    for (int ln = 0; ln < VT; ln++) begin
      len = (ln == short_line) ? HT - 1 : HT;
      for (int h = 0; h < len; h++) begin
        @(posedge clk); #1;
        if (ln == rst_line && h == 10) reset = 1'b1;
        if (ln == rst_line && h == 13) reset = 1'b0;
        vis = (ln >= VS + VB) && (ln < VS + VB + VD) && (h >= HS + HB) && (h < HS + HB + HD);
        col = vis ? img[ln - VS - VB][h - HS - HB] : blank_col;
        vga_in = pack(h < HS, ln < VS, col);
        @(negedge clk);
        if (frame_done) begin pulses++; pulse_pos = cyc; end
        if (cyc == 3) begin
          s_x = dot_x; s_y = dot_y; s_found = dot_found; s_count = dot_count;
          s_dx = dir_x; s_dy = dir_y; s_lock = locked;
        end
        if (ln == rst_line && h == 15) begin
          z_x = dot_x; z_y = dot_y; z_found = dot_found; z_count = dot_count;
          z_dx = dir_x; z_dy = dir_y; z_lock = locked; z_done = frame_done;
        end
        cyc++;
      end
    end
    s_lock_end = locked;
  endtask

  // One full frame plus all checks of the boundary that opened it.
  task automatic step(input string tag, input int short_line, input int rst_line);
    run_frame(short_line, rst_line);
    if (prev_complete) begin
      m_count = (pend_cnt > 15) ? 15 : pend_cnt;
      m_found = (pend_cnt != 0);
      m_x = m_found ? 10'(pend_x) : 10'd0;
      m_y = m_found ? 10'(pend_y) : 10'd0;
      if (m_found) begin
        if (m_have) begin
          if (m_x > m_px) m_dx = 1'b1; else if (m_x < m_px) m_dx = 1'b0;
          if (m_y > m_py) m_dy = 1'b1; else if (m_y < m_py) m_dy = 1'b0;
        end
        m_px = m_x; m_py = m_y; m_have = 1'b1;
      end
    end
    m_lock = (prev_complete && prev_good) ? ((m_lock == 2) ? 2 : m_lock + 1) : 0;

    chk({tag, ".pulses"}, pulses, prev_complete ? 1 : 0);
    if (prev_complete) chk({tag, ".pulse_pos"}, pulse_pos, 2);
    chk({tag, ".dot_found"}, s_found, m_found);
    chk({tag, ".dot_count"}, s_count, m_count);
    chk({tag, ".dot_x"}, s_x, m_x);
    chk({tag, ".dot_y"}, s_y, m_y);
    chk({tag, ".dir_x"}, s_dx, m_dx);
    chk({tag, ".dir_y"}, s_dy, m_dy);
    chk({tag, ".locked"}, s_lock, (m_lock == 2) ? 1 : 0);

    if (rst_line >= 0) begin
      m_x = 0; m_y = 0; m_found = 0; m_count = 0; m_dx = 0; m_dy = 0;
      m_have = 0; m_lock = 0;
    end
    chk({tag, ".locked_end"}, s_lock_end,
        (rst_line >= 0 || short_line >= 0) ? 0 : ((m_lock == 2) ? 1 : 0));

    frame_stats(key_color, pend_cnt, pend_x, pend_y);
    prev_complete = (rst_line < 0);
    prev_good = (short_line < 0);
  endtask

  initial begin
    int xs [7] = '{15, 16, 17, 18, 19, 18, 17};

    key_color = 6'h2A;
    blank_col = ~key_color;
    vga_in = pack(1'b0, 1'b0, 6'h00);
    fill(~key_color);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst.dot_x", dot_x, 0);
    chk("rst.dot_y", dot_y, 0);
    chk("rst.dot_found", dot_found, 0);
    chk("rst.dot_count", dot_count, 0);
    chk("rst.dir_x", dir_x, 0);
    chk("rst.dir_y", dir_y, 0);
    chk("rst.frame_done", frame_done, 0);
    chk("rst.locked", locked, 0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (5) @(posedge clk);

    // Single key pixel, inverse colour elsewhere
    img[7][5] = key_color;
    step("single0", -1, -1);
    step("single1", -1, -1);
    step("single2", -1, -1);

    // No matching pixel
    fill(~key_color);
    step("nomatch", -1, -1);

    // Key colour in blanking plus 20 visible matches
    blank_col = key_color;
    for (int i = 0; i < 20; i++) img[3 + i / 10][2 + i % 10] = key_color;
    step("blank20", -1, -1);

    // One short line, then clean frames to regain lock
    blank_col = ~key_color;
    fill(~key_color);
    img[7][5] = key_color;
    step("short", 8, -1);
    step("relock1", -1, -1);
    step("relock2", -1, -1);

    // Moving dot: +1 x / -1 y per frame, reversing in x at 19
    for (int i = 0; i < 7; i++) begin
      fill(~key_color);
      img[12 - i][xs[i]] = key_color;
      step("move", -1, -1);
    end

    // Random images, keys and blanking colours
    for (int r = 0; r < 8; r++) begin
      key_color = 6'($urandom);
      blank_col = 6'($urandom);
      for (int y = 0; y < VD; y++)
        for (int x = 0; x < HD; x++)
          img[y][x] = ($urandom_range(0, 11) == 0) ? key_color : 6'($urandom);
      step("random", -1, -1);
    end

    // Reset in the middle of a frame
    key_color = 6'h15;
    blank_col = ~key_color;
    fill(~key_color);
    img[9][3] = key_color;
    step("midrst", -1, 10);
    chk("midrst.dot_x", z_x, 0);
    chk("midrst.dot_y", z_y, 0);
    chk("midrst.dot_found", z_found, 0);
    chk("midrst.dot_count", z_count, 0);
    chk("midrst.dir_x", z_dx, 0);
    chk("midrst.dir_y", z_dy, 0);
    chk("midrst.locked", z_lock, 0);
    chk("midrst.frame_done", z_done, 0);
    step("post_rst1", -1, -1);
    step("post_rst2", -1, -1);
    step("tail", -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
